// File: rtl/scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment table and blank code.
// Latency: none (constants only).
// Backpressure: not applicable.
package scan_display_pkg;

    // Active-low {a,b,c,d,e,f,g,dp}; entry n is the pattern for hex digit n (index 15 leftmost)
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         SEG_DP_BIT = 0;

endpackage

// File: rtl/scan_display_n_if.sv
// Bundle of display-data inputs and scanned segment/anode outputs.
// Latency: none (wiring only).
// Backpressure: none; load is a fire-and-forget strobe.
interface scan_display_n_if #(
    parameter int DIGITS   = 8,
    parameter int PWM_BITS = 4
);
    localparam int WW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic                lz_en;
    logic                load;
    logic [PWM_BITS-1:0] bright;
    logic [WW-1:0]       which;
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                frame;

    modport master (
        output data, dp, lz_en, load, bright,
        input  which, an, seg, frame
    );

    modport slave (
        input  data, dp, lz_en, load, bright,
        output which, an, seg, frame
    );
endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern with decimal point and blank override.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    // Table lookup, then dp, then blanking wins over everything
    always_comb begin
        seg = SEG_TABLE[nibble];
        if (dp) begin
            seg[SEG_DP_BIT] = 1'b0;
        end
        if (blank) begin
            seg = SEG_BLANK;
        end
    end
endmodule

// File: rtl/scan_display_n.sv
// Time-multiplexed N-digit hex display driver with PWM dimming and leading-zero blanking.
// Latency: seg/an registered, valid one clock after which changes; new data shows from the next frame.
// Backpressure: none; a load is always accepted and the latest one wins until the frame boundary.
module scan_display_n #(
    parameter int DIGITS   = 8,
    parameter int DIV_BITS = 11,
    parameter int PWM_BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    scan_display_n_if.slave bus
);
    import scan_display_pkg::*;

    localparam int            WW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [WW-1:0] LAST = WW'(DIGITS - 1);

    logic [DIV_BITS-1:0] cnt;
    logic                tick;
    logic                wrap;
    logic [WW-1:0]       which;
    logic                frame;

    logic                pending;
    logic [4*DIGITS-1:0] stg_data;
    logic [DIGITS-1:0]   stg_dp;
    logic                stg_lz;
    logic [4*DIGITS-1:0] disp_data;
    logic [DIGITS-1:0]   disp_dp;
    logic                disp_lz;

    logic [DIGITS-1:0]   lz_mask;
    logic                nz_acc;
    logic [WW-1:0]       pos;
    logic [PWM_BITS-1:0] phase;
    logic                lit;
    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   an_d;
    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   an_q;

    assign tick = &cnt;
    assign wrap = tick && (which == LAST);

    // Prescaler, scan index and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            which <= '0;
            frame <= 1'b0;
        end else begin
            cnt   <= cnt + DIV_BITS'(1);
            frame <= wrap;
            if (tick) begin
                which <= wrap ? '0 : which + WW'(1);
            end
        end
    end

    // Staging capture; a load on the wrap cycle wins over the clear so it waits a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            stg_data <= '0;
            stg_dp   <= '0;
            stg_lz   <= 1'b0;
        end else if (bus.load) begin
            pending  <= 1'b1;
            stg_data <= bus.data;
            stg_dp   <= bus.dp;
            stg_lz   <= bus.lz_en;
        end else if (wrap) begin
            pending  <= 1'b0;
        end
    end

    // Display register only changes at the frame boundary so a frame is never torn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data <= '0;
            disp_dp   <= '0;
            disp_lz   <= 1'b0;
        end else if (wrap && pending) begin
            disp_data <= stg_data;
            disp_dp   <= stg_dp;
            disp_lz   <= stg_lz;
        end
    end

    // Leading-zero mask: prefix-OR of nonzero nibbles from the leftmost position down
    always_comb begin
        nz_acc  = 1'b0;
        lz_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_acc     = nz_acc | (|disp_data[4*i +: 4]);
            lz_mask[i] = disp_lz & ~nz_acc & ~disp_dp[i] & (i != 0);
        end
    end

    // which=0 scans the leftmost position; digit is dark outside the PWM window and on the scan edge
    assign pos   = LAST - which;
    assign phase = cnt[DIV_BITS-1 -: PWM_BITS];
    assign lit   = (phase < bus.bright) && !tick;
    assign an_d  = lit ? ~(DIGITS'(1) << which) : '1;

    seg7_decode u_dec (
        .nibble (disp_data[{pos, 2'b00} +: 4]),
        .dp     (disp_dp[pos]),
        .blank  (lz_mask[pos] | ~lit),
        .seg    (seg_d)
    );

    // Registered pin drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.which = which;
    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame;
endmodule

// File: tb/tb_scan_display_n.sv
module tb_scan_display_n;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    scan_display_n_if #(.DIGITS(8), .PWM_BITS(2)) if_a ();
    scan_display_n_if #(.DIGITS(6), .PWM_BITS(2)) if_b ();
    scan_display_n_if #(.DIGITS(8), .PWM_BITS(2)) if_c ();

    scan_display_n #(.DIGITS(8), .DIV_BITS(3), .PWM_BITS(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    scan_display_n #(.DIGITS(6), .DIV_BITS(3), .PWM_BITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    scan_display_n #(.DIGITS(8), .DIV_BITS(4), .PWM_BITS(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lz;
        logic [7:0]  dp;
        logic [31:0] data;
        int          which;
        logic [7:0]  seg;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic lz, input logic [7:0] dp, input logic [31:0] data,
                       input int w, input logic [7:0] seg);
        vec_t v;
        v.lz = lz; v.dp = dp; v.data = data; v.which = w; v.seg = seg;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame_a();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!if_a.frame && n < 200);
        if (!if_a.frame) timeout("wait_frame_a");
    endtask

    task automatic load_a(input logic [31:0] data, input logic [7:0] dp, input logic lz);
        if_a.data  = data;
        if_a.dp    = dp;
        if_a.lz_en = lz;
        if_a.load  = 1'b1;
        step();
        if_a.load  = 1'b0;
        wait_frame_a();
        wait_frame_a();
    endtask

    // Align to the start of slot k, then sample two clocks in (inside the lit PWM window)
    task automatic show_a(input int k, input logic [7:0] exp_seg, input string name);
        int n;
        logic [7:0] exp_an;
        n = 0;
        while (int'(if_a.which) == k && n < 100) begin step(); n++; end
        while (int'(if_a.which) != k && n < 200) begin step(); n++; end
        if (int'(if_a.which) != k) begin
            timeout(name);
        end else begin
            step();
            step();
            exp_an = ~(8'd1 << k);
            check({name, " seg"}, {24'd0, if_a.seg}, {24'd0, exp_seg});
            check({name, " an"},  {24'd0, if_a.an},  {24'd0, exp_an});
        end
    endtask

    initial begin
        logic [31:0] cur_data;
        logic [7:0]  cur_dp;
        logic        cur_lz;
        bit          have;
        int          cyc;
        int          lows;
        int          first_low;
        int          bad_hot;
        int          n9f;
        int          exp_seq[5];
        logic [2:0]  prev_w;

        rst_n = 1'b1;
        if_a.data = '0; if_a.dp = '0; if_a.lz_en = 1'b0; if_a.load = 1'b0; if_a.bright = 2'd3;
        if_b.data = '0; if_b.dp = '0; if_b.lz_en = 1'b0; if_b.load = 1'b0; if_b.bright = 2'd3;
        if_c.data = '0; if_c.dp = '0; if_c.lz_en = 1'b0; if_c.load = 1'b0; if_c.bright = 2'd1;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst seg", {24'd0, if_a.seg}, 32'hFF);
        check("rst an", {24'd0, if_a.an}, 32'hFF);
        check("rst which", {29'd0, if_a.which}, 32'd0);
        check("rst frame", {31'd0, if_a.frame}, 32'd0);
        check("rst an b", {26'd0, if_b.an}, 32'h3F);
        repeat (3) step();
        rst_n = 1'b1;

        // Scan cadence on 6 digits: first tick 8 clocks after release, slot order, frame period
        cyc = 0;
        do begin step(); cyc++; end while (if_b.which != 3'd1 && cyc < 100);
        check("b first tick", cyc, 8);
        exp_seq = '{2, 3, 4, 5, 0};
        prev_w = 3'd1;
        for (int i = 0; i < 5; i++) begin
            cyc = 0;
            do begin step(); cyc++; end while (if_b.which == prev_w && cyc < 100);
            check("b which seq", {29'd0, if_b.which}, exp_seq[i]);
            check("b dwell", cyc, 8);
            prev_w = if_b.which;
        end
        check("b frame on wrap", {31'd0, if_b.frame}, 32'd1);
        step();
        check("b frame width", {31'd0, if_b.frame}, 32'd0);
        cyc = 1;
        do begin step(); cyc++; end while (!if_b.frame && cyc < 200);
        check("b frame period", cyc, 48);

        // PWM window with bright=1, 16-clock slot: guard cycle then 4 lit clocks
        for (int s = 0; s < 2; s++) begin
            prev_w = if_c.which;
            cyc = 0;
            while (if_c.which == prev_w && cyc < 100) begin step(); cyc++; end
            if (if_c.which == prev_w) begin
                timeout("c slot change");
            end else begin
                check("c guard an", {24'd0, if_c.an}, 32'hFF);
                lows = 0; first_low = -1; bad_hot = 0;
                for (int t = 0; t < 16; t++) begin
                    if (if_c.an != 8'hFF) begin
                        lows++;
                        if (first_low < 0) first_low = t;
                    end
                    if ($countones(~if_c.an) > 1) bad_hot++;
                    step();
                end
                check("c lit clocks", lows, 4);
                check("c first lit offset", first_low, 1);
                check("c one-hot", bad_hot, 0);
            end
        end

        // Decode table on the 8-digit display
        add(0, 8'h00, 32'h76543210, 0, 8'h1F); add(0, 8'h00, 32'h76543210, 1, 8'h41);
        add(0, 8'h00, 32'h76543210, 2, 8'h49); add(0, 8'h00, 32'h76543210, 3, 8'h99);
        add(0, 8'h00, 32'h76543210, 4, 8'h0D); add(0, 8'h00, 32'h76543210, 5, 8'h25);
        add(0, 8'h00, 32'h76543210, 6, 8'h9F); add(0, 8'h00, 32'h76543210, 7, 8'h03);
        add(0, 8'h00, 32'hFEDCBA98, 0, 8'h71); add(0, 8'h00, 32'hFEDCBA98, 1, 8'h61);
        add(0, 8'h00, 32'hFEDCBA98, 2, 8'h85); add(0, 8'h00, 32'hFEDCBA98, 3, 8'h63);
        add(0, 8'h00, 32'hFEDCBA98, 4, 8'hC1); add(0, 8'h00, 32'hFEDCBA98, 5, 8'h11);
        add(0, 8'h00, 32'hFEDCBA98, 6, 8'h09); add(0, 8'h00, 32'hFEDCBA98, 7, 8'h01);
        add(0, 8'h00, 32'h01234567, 0, 8'h03); add(0, 8'h00, 32'h01234567, 7, 8'h1F);
        add(0, 8'h00, 32'h01234567, 5, 8'h49);
        add(0, 8'h81, 32'h01234567, 0, 8'h02); add(0, 8'h81, 32'h01234567, 7, 8'h1E);
        add(0, 8'h81, 32'h01234567, 1, 8'h9F);
        add(1, 8'h00, 32'h00000A00, 0, 8'hFF); add(1, 8'h00, 32'h00000A00, 1, 8'hFF);
        add(1, 8'h00, 32'h00000A00, 2, 8'hFF); add(1, 8'h00, 32'h00000A00, 3, 8'hFF);
        add(1, 8'h00, 32'h00000A00, 4, 8'hFF); add(1, 8'h00, 32'h00000A00, 5, 8'h11);
        add(1, 8'h00, 32'h00000A00, 6, 8'h03); add(1, 8'h00, 32'h00000A00, 7, 8'h03);
        add(1, 8'h00, 32'h00000000, 0, 8'hFF); add(1, 8'h00, 32'h00000000, 3, 8'hFF);
        add(1, 8'h00, 32'h00000000, 6, 8'hFF); add(1, 8'h00, 32'h00000000, 7, 8'h03);
        add(1, 8'h08, 32'h00000000, 4, 8'h02); add(1, 8'h08, 32'h00000000, 0, 8'hFF);
        add(1, 8'h08, 32'h00000000, 7, 8'h03);

        have = 1'b0;
        cur_data = '0; cur_dp = '0; cur_lz = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            if (!have || vt[i].data != cur_data || vt[i].dp != cur_dp || vt[i].lz != cur_lz) begin
                load_a(vt[i].data, vt[i].dp, vt[i].lz);
                cur_data = vt[i].data; cur_dp = vt[i].dp; cur_lz = vt[i].lz;
                have = 1'b1;
            end
            show_a(vt[i].which, vt[i].seg, $sformatf("vec%0d", i));
        end

        // Two loads inside one frame: only the later one is ever displayed
        wait_frame_a();
        if_a.data = 32'h11111111; if_a.dp = 8'h00; if_a.lz_en = 1'b0; if_a.load = 1'b1;
        step();
        if_a.load = 1'b0;
        step();
        if_a.data = 32'h22222222; if_a.load = 1'b1;
        step();
        if_a.load = 1'b0;
        n9f = 0;
        cyc = 0;
        do begin
            if (if_a.seg == 8'h9F) n9f++;
            step();
            cyc++;
        end while (!if_a.frame && cyc < 200);
        if (!if_a.frame) timeout("overwrite frame");
        for (int t = 0; t < 64; t++) begin
            if (if_a.seg == 8'h9F) n9f++;
            step();
        end
        check("overwrite no 9F", n9f, 0);
        show_a(3, 8'h25, "overwrite shows 2");

        // Reset with a load pending: outputs blank at once, pending load is discarded
        wait_frame_a();
        if_a.data = 32'h12345678; if_a.dp = 8'h00; if_a.lz_en = 1'b0; if_a.load = 1'b1;
        step();
        if_a.load = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("async rst seg", {24'd0, if_a.seg}, 32'hFF);
        check("async rst an", {24'd0, if_a.an}, 32'hFF);
        check("async rst which", {29'd0, if_a.which}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_frame_a();
        wait_frame_a();
        show_a(0, 8'h03, "post-rst pos7");
        show_a(7, 8'h03, "post-rst pos0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
